hilo_muldiv: RTL
================

Name: hilo_muldiv

Overview:
- Owns the architectural HI/LO register pair and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- It is the producer side of the HI/LO values that the decode stage reads through hi_new/lo_new.
- Sits beside the execute stage. Multiply takes a fixed number of cycles; divide is an iterative 32-step unit.
- Raises a stall while busy so the pipeline never reads a stale HI/LO or issues a second operation.

Parameters:
- MUL_LAT, 4, cycles from acceptance to HI/LO update for MULT/MULTU; legal range 1..16.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a HI/LO operation this cycle
- req_op  in  3  muldiv_op_t: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
- src_a  in  32  rs value (dividend / multiplicand / MTHI/MTLO data)
- src_b  in  32  rt value (divisor / multiplier)
- hilo_rd  in  1  decode stage holds MFHI/MFLO this cycle
- hi_new  out  32  current HI register
- lo_new  out  32  current LO register
- busy  out  1  a MUL or DIV operation is in flight
- stall  out  1  pipeline must hold decode and execute this cycle

Behaviour:
- Reset (resetn low, asynchronous): HI=0, LO=0, state=IDLE, cnt=0. Outputs: hi_new=0, lo_new=0, busy=0, stall=0.
- States: IDLE, MUL, DIV. busy = (state != IDLE), a registered decode.
- Acceptance: happens on a clock edge with state==IDLE, req_valid=1 and req_op != MD_NONE.
  - While busy, requests are not accepted. stall is asserted and execute holds req_op, src_a and src_b stable until the request is accepted.
- stall = busy && (hilo_rd || (req_valid && req_op != MD_NONE)). Purely combinational; 0 in IDLE.
- MTHI/MTLO:
  - Accepted in IDLE.
  - HI (or LO) takes src_a at the accept edge and is visible on the next cycle.
  - State stays IDLE.
- MULT/MULTU:
  - At the accept edge, latch the operands and go to MUL with cnt = MUL_LAT-1.
  - Each edge in MUL: if cnt==0, write {HI,LO} = 64-bit product and go to IDLE; otherwise cnt--.
  - busy is high for exactly MUL_LAT cycles.
  - MULT is signed 32x32->64; MULTU is unsigned.
- DIV/DIVU:
  - At the accept edge, latch |a| and |b| (raw values for DIVU), the quotient and remainder signs, and the op. Go to DIV with cnt=31.
  - Each edge performs one radix-2 restoring step: shift in the next dividend bit MSB-first, trial-subtract, set the quotient bit.
  - On the edge with cnt==0: apply sign fix-up, write LO=quotient and HI=remainder, go to IDLE.
  - busy is high for exactly 32 cycles.
- Signed rules: quotient negative iff sign(a) != sign(b); remainder takes the sign of a. Both are truncated toward zero.
- 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0. The magnitude path must be 32-bit unsigned so |INT_MIN| is correct.
- Divide by zero:
  - No trap. Result is the natural restoring output: LO=0xFFFFFFFF (DIVU) and HI=a.
  - For DIV, the same raw result is used before sign fix-up, and fix-up is suppressed when b==0.
- hilo_rd in the completion cycle: the cycle after the writing edge is IDLE, so stall=0 and decode sees the new HI/LO.
- Reset mid-operation: the in-flight result is discarded; HI/LO = 0 and IDLE immediately.
- The op code is sampled only at acceptance. Changes to req_op or src_* during MUL/DIV are ignored.

Decomposition:
- pipeline.svh package: muldiv_op_t enum (3 bits, MD_NONE=0), hilo_state_t enum, and the MUL_LAT default constant.
- One sub-module, divu_core: a 32-cycle unsigned restoring divider.
  - Interface: start, dividend, divisor, done, quot, rem.
  - hilo_muldiv wraps it with sign handling. The multiply datapath stays inline.

Test Plan:
- Reset then idle: hi_new=0, lo_new=0, busy=0, stall=0. Apply MTHI 0x12345678, then MTLO 0x9ABCDEF0 on the next cycle -> HI/LO read back those values one cycle after each.
- MULT src_a=0xFFFFFFFE (-2), src_b=3 with MUL_LAT=4 -> busy high exactly 4 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7 / 2 -> busy 32 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 -> LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- During DIV, hold hilo_rd=1 and a second MULT request -> stall=1 for all 32 busy cycles. The MULT is accepted on the first IDLE edge, and its result overwrites the DIV result after MUL_LAT more cycles.
- Deassert resetn at cycle 10 of a DIV after HI/LO were preloaded with nonzero values -> HI/LO become 0 and busy drops asynchronously. After release, the first request is accepted normally.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: shared op codes, FSM state constants and defaults for the HI/LO unit.
package hilo_muldiv_pkg;
   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } muldiv_op_t;
   typedef logic [1:0] hilo_state_t;
   localparam hilo_state_t ST_IDLE = 2'd0;
   localparam hilo_state_t ST_MUL  = 2'd1;
   localparam hilo_state_t ST_DIV  = 2'd2;
   localparam int MUL_LAT_DEF = 4;
endpackage

// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: request/result bundle between the execute/decode stages and the HI/LO unit.
interface hilo_muldiv_if;
   import hilo_muldiv_pkg::*;
   logic        req_valid;
   muldiv_op_t  req_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        hilo_rd;
   logic [31:0] hi_new;
   logic [31:0] lo_new;
   logic        busy;
   logic        stall;
   modport master (output req_valid, req_op, src_a, src_b, hilo_rd,
                   input  hi_new, lo_new, busy, stall);
   modport slave  (input  req_valid, req_op, src_a, src_b, hilo_rd,
                   output hi_new, lo_new, busy, stall);
endinterface

// File: rtl/hilo_muldiv_divu_core.sv
// divu_core: 32-step unsigned radix-2 restoring divider; quot/rem show the result of the current step.
module divu_core (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        done,
   output logic [31:0] quot,
   output logic [31:0] rem
);
   logic [31:0] q, r, d;
   logic [4:0]  cnt;
   logic        run;
   logic [32:0] rs, diff;
   logic        ge;
   // q shifts dividend bits out MSB-first while quotient bits shift in at the bottom
   assign rs   = {r, q[31]};
   assign diff = rs - {1'b0, d};
   assign ge   = ~diff[32];
   assign rem  = ge ? diff[31:0] : rs[31:0];
   assign quot = {q[30:0], ge};
   assign done = run && cnt == 5'd0;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         q <= '0;
         r <= '0;
         d <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         q <= dividend;
         r <= '0;
         d <= divisor;
         cnt <= 5'd31;
         run <= 1'b1;
      end else if (run) begin
         q <= quot;
         r <= rem;
         cnt <= cnt - 5'd1;
         if (cnt == 5'd0) run <= 1'b0;
      end
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with fixed-latency multiply, iterative divide and MTHI/MTLO.
module hilo_muldiv
   import hilo_muldiv_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input logic            clk,
   input logic            resetn,
   hilo_muldiv_if.slave   bus
);
   hilo_state_t state;
   logic [4:0]  cnt;
   logic [31:0] hi, lo, ma, mb, a_mag, b_mag, quot, rem;
   logic        msigned, q_neg, r_neg, accept, is_mul, is_div, sdiv, b_nz, div_done;
   logic [63:0] prod;
   assign accept = state == ST_IDLE && bus.req_valid && bus.req_op != MD_NONE;
   assign is_mul = bus.req_op == MD_MULT || bus.req_op == MD_MULTU;
   assign is_div = bus.req_op == MD_DIV || bus.req_op == MD_DIVU;
   assign sdiv   = bus.req_op == MD_DIV;
   assign b_nz   = bus.src_b != 32'd0;
   // magnitudes stay 32-bit unsigned so |INT_MIN| = 0x80000000 is exact
   assign a_mag  = (sdiv && bus.src_a[31]) ? -bus.src_a : bus.src_a;
   assign b_mag  = (sdiv && bus.src_b[31]) ? -bus.src_b : bus.src_b;
   assign prod   = {{32{msigned & ma[31]}}, ma} * {{32{msigned & mb[31]}}, mb};
   divu_core u_div (
      .clk(clk), .resetn(resetn), .start(accept && is_div),
      .dividend(a_mag), .divisor(b_mag), .done(div_done), .quot(quot), .rem(rem)
   );
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state <= ST_IDLE;
         cnt <= '0;
         hi <= '0;
         lo <= '0;
         ma <= '0;
         mb <= '0;
         msigned <= 1'b0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (accept) begin
         if (bus.req_op == MD_MTHI) hi <= bus.src_a;
         if (bus.req_op == MD_MTLO) lo <= bus.src_a;
         if (is_mul) begin
            state <= ST_MUL;
            cnt <= 5'(MUL_LAT - 1);
            ma <= bus.src_a;
            mb <= bus.src_b;
            msigned <= bus.req_op == MD_MULT;
         end
         if (is_div) begin
            state <= ST_DIV;
            q_neg <= sdiv && b_nz && (bus.src_a[31] ^ bus.src_b[31]);
            r_neg <= sdiv && b_nz && bus.src_a[31];
         end
      end else if (state == ST_MUL) begin
         if (cnt == 5'd0) begin
            {hi, lo} <= prod;
            state <= ST_IDLE;
         end else cnt <= cnt - 5'd1;
      end else if (state == ST_DIV && div_done) begin
         lo <= q_neg ? -quot : quot;
         hi <= r_neg ? -rem : rem;
         state <= ST_IDLE;
      end
   assign bus.hi_new = hi;
   assign bus.lo_new = lo;
   assign bus.busy   = state != ST_IDLE;
   assign bus.stall  = bus.busy && (bus.hilo_rd || (bus.req_valid && bus.req_op != MD_NONE));
endmodule
